// File: rtl/bb_adc_pkg.sv
// Shared definitions for the BB ADC readout path: state encodings, the
// default data width and the accumulator width rule.
package bb_adc_pkg;

  localparam int DW_DEFAULT = 12;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_GAP     = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_REQ     = ST_REQ,
    S_RELEASE = ST_RELEASE,
    S_GAP     = ST_GAP
  } readout_state_t;

  // Up to 8 samples of DW bits each: three extra bits hold 8*(2^DW-1).
  function automatic int acc_width(input int dw);
    return dw + 3;
  endfunction

endpackage

// File: rtl/bb_cycle_timer.sv
// CE-qualified up-counter with synchronous clear and a terminal-count
// compare against a caller-supplied value.
module bb_cycle_timer
  import bb_adc_pkg::*;
#(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          clr,
  input  logic          inc,
  input  logic [TW-1:0] term,
  output logic          tc
);

  logic [TW-1:0] count;

  // Count register: clear wins over increment; frozen when ce is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (ce) begin
      if (clr) begin
        count <= '0;
      end else if (inc) begin
        count <= count + TW'(1);
      end
    end
  end

  assign tc = (count == term);

endmodule

// File: rtl/bb_adc_readout.sv
// Requests NSAMP+1 conversions from the BB ADC controller, sums the
// captured words and presents the sum with VALID; flags a stalled
// controller with a sticky TIMEOUT.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for START with DATAREADY low
// REQ     | STROBE/READBB high, waiting for DATAREADY (timed)
// RELEASE | sample captured, waiting for DATAREADY to drop
// GAP     | idle spacing before the next sample request
module bb_adc_readout
  import bb_adc_pkg::*;
#(
  parameter int DW  = DW_DEFAULT,
  parameter int TMO = 255,
  parameter int GAP = 2
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          CE,
  input  logic          START,
  input  logic [2:0]    NSAMP,
  input  logic          DATAREADY,
  input  logic [DW-1:0] ADC_DOUT,
  output logic          STROBE,
  output logic          READBB,
  output logic [DW+2:0] RESULT,
  output logic          VALID,
  output logic          BUSY,
  output logic          TIMEOUT
);

  localparam int AW = acc_width(DW);
  localparam int TW = $clog2(((TMO > GAP) ? TMO : GAP) + 1);

  readout_state_t state, state_nx;
  logic [AW-1:0]  acc, acc_nx;
  logic [2:0]     remaining, remaining_nx;
  logic           strobe_nx;
  logic [AW-1:0]  result_nx;
  logic           valid_nx, busy_nx, timeout_nx;
  logic           timer_clr, timer_inc, timer_tc;
  logic [TW-1:0]  timer_term;

  // One timer serves both the request timeout and the inter-sample gap.
  assign timer_term = (state == S_GAP) ? TW'(GAP - 1) : TW'(TMO - 1);

  bb_cycle_timer #(.TW(TW)) u_timer (
    .clk   (CLK),
    .rst_n (RST_N),
    .ce    (CE),
    .clr   (timer_clr),
    .inc   (timer_inc),
    .term  (timer_term),
    .tc    (timer_tc)
  );

  // State and output registers; everything holds while CE is low.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      acc       <= '0;
      remaining <= '0;
      STROBE    <= 1'b0;
      READBB    <= 1'b0;
      RESULT    <= '0;
      VALID     <= 1'b0;
      BUSY      <= 1'b0;
      TIMEOUT   <= 1'b0;
    end else if (CE) begin
      state     <= state_nx;
      acc       <= acc_nx;
      remaining <= remaining_nx;
      STROBE    <= strobe_nx;
      READBB    <= strobe_nx;
      RESULT    <= result_nx;
      VALID     <= valid_nx;
      BUSY      <= busy_nx;
      TIMEOUT   <= timeout_nx;
    end
  end

  // Next-state and next-output logic; capture takes priority over timeout.
  always_comb begin
    state_nx     = state;
    acc_nx       = acc;
    remaining_nx = remaining;
    strobe_nx    = STROBE;
    result_nx    = RESULT;
    valid_nx     = VALID;
    busy_nx      = BUSY;
    timeout_nx   = TIMEOUT;
    timer_clr    = 1'b0;
    timer_inc    = 1'b0;

    case (state)
      S_IDLE: begin
        if (START && !DATAREADY) begin
          state_nx     = S_REQ;
          strobe_nx    = 1'b1;
          busy_nx      = 1'b1;
          valid_nx     = 1'b0;
          timeout_nx   = 1'b0;
          acc_nx       = '0;
          remaining_nx = NSAMP;
          timer_clr    = 1'b1;
        end
      end

      S_REQ: begin
        if (DATAREADY) begin
          acc_nx    = acc + AW'(ADC_DOUT);
          strobe_nx = 1'b0;
          state_nx  = S_RELEASE;
        end else if (timer_tc) begin
          strobe_nx  = 1'b0;
          timeout_nx = 1'b1;
          busy_nx    = 1'b0;
          state_nx   = S_IDLE;
        end else begin
          timer_inc = 1'b1;
        end
      end

      S_RELEASE: begin
        if (!DATAREADY) begin
          if (remaining == 3'd0) begin
            result_nx = acc;
            valid_nx  = 1'b1;
            busy_nx   = 1'b0;
            state_nx  = S_IDLE;
          end else begin
            remaining_nx = remaining - 3'd1;
            timer_clr    = 1'b1;
            state_nx     = S_GAP;
          end
        end
      end

      S_GAP: begin
        if (timer_tc) begin
          strobe_nx = 1'b1;
          timer_clr = 1'b1;
          state_nx  = S_REQ;
        end else begin
          timer_inc = 1'b1;
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bb_adc_readout.sv
// Directed-plus-random bench for bb_adc_readout with a behavioural model
// of the conversion controller and of the expected sums and timing.
module tb_bb_adc_readout;

  localparam int DW  = 12;
  localparam int TMO = 20;
  localparam int GAP = 2;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          CE = 1'b0;
  logic          START = 1'b0;
  logic [2:0]    NSAMP = 3'd0;
  logic          DATAREADY = 1'b0;
  logic [DW-1:0] ADC_DOUT = '0;
  logic          STROBE, READBB, VALID, BUSY, TIMEOUT;
  logic [DW+2:0] RESULT;

  int checks = 0;
  int errors = 0;

  // controller model: 0 normal, 1 never answers, 2 inputs driven by hand
  int c_mode = 0;
  int c_cnt = 0;
  int c_delay = 3;
  int fixed_delay = 0;
  int ce_mode = 0;
  int ce_phase = 0;
  int data_q[$];
  int exp_sum = 0;
  int exp_result = 0;

  int ce_cyc = 0, rise_cyc = 0, fall_cyc = 0, pulses = 0;
  int min_low = 1000, valid_low = -1, to_delay = -1;
  bit have_fall = 0;
  logic strobe_prev = 0, valid_prev = 0, timeout_prev = 0;
  bit frz_en = 0;
  int frozen_err = 0;
  logic [19:0] snap = '0;

  bb_adc_readout #(.DW(DW), .TMO(TMO), .GAP(GAP)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .CE        (CE),
    .START     (START),
    .NSAMP     (NSAMP),
    .DATAREADY (DATAREADY),
    .ADC_DOUT  (ADC_DOUT),
    .STROBE    (STROBE),
    .READBB    (READBB),
    .RESULT    (RESULT),
    .VALID     (VALID),
    .BUSY      (BUSY),
    .TIMEOUT   (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int pick_delay();
    return (fixed_delay > 0) ? fixed_delay : int'($urandom_range(3, 6));
  endfunction

  // One clock: observe at the falling edge, run the controller model for
  // CE-qualified edges, then choose CE for the next rising edge.
  task automatic tick();
    logic ce_was;
    logic [19:0] now;
    int v;
    @(negedge CLK);
    ce_was = CE;
    now = {STROBE, READBB, VALID, BUSY, TIMEOUT, RESULT};
    if (frz_en && !ce_was && now !== snap) frozen_err++;
    snap = now;
    if (ce_was) begin
      ce_cyc++;
      if (STROBE && !strobe_prev) begin
        pulses++;
        if (have_fall && (ce_cyc - fall_cyc) < min_low) min_low = ce_cyc - fall_cyc;
        rise_cyc = ce_cyc;
      end
      if (!STROBE && strobe_prev) begin
        fall_cyc = ce_cyc;
        have_fall = 1;
      end
      if (TIMEOUT && !timeout_prev) to_delay = ce_cyc - rise_cyc;
      if (VALID && !valid_prev) valid_low = ce_cyc - fall_cyc;
      strobe_prev = STROBE;
      timeout_prev = TIMEOUT;
      valid_prev = VALID;
      if (c_mode == 0) begin
        if (DATAREADY) begin
          if (!STROBE) DATAREADY = 1'b0;
        end else if (STROBE) begin
          c_cnt++;
          if (c_cnt >= c_delay) begin
            if (data_q.size() > 0) v = data_q.pop_front();
            else v = int'($urandom_range(0, (1 << DW) - 1));
            ADC_DOUT = DW'(v);
            DATAREADY = 1'b1;
            exp_sum += v;
            c_cnt = 0;
            c_delay = pick_delay();
          end
        end else begin
          c_cnt = 0;
        end
      end
    end
    case (ce_mode)
      0: CE = 1'b1;
      1: begin
        ce_phase = (ce_phase + 1) % 3;
        CE = (ce_phase == 0);
      end
      default: CE = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic seq_init();
    exp_sum = 0;
    pulses = 0;
    have_fall = 0;
    min_low = 1000;
    valid_low = -1;
    to_delay = -1;
    c_cnt = 0;
    c_delay = pick_delay();
  endtask

  task automatic run_seq(input int ns, input bit poke, input int budget, output bit ok);
    int n = 0;
    int m = 0;
    seq_init();
    NSAMP = 3'(ns);
    START = 1'b1;
    while (!BUSY && n < budget) begin
      tick();
      n++;
    end
    START = 1'b0;
    NSAMP = 3'($urandom_range(0, 7));
    while (BUSY && n < budget) begin
      START = poke && (m >= 2) && (m <= 4);
      tick();
      n++;
      m++;
    end
    START = 1'b0;
    ok = (n < budget) && !BUSY;
  endtask

  initial begin
    bit ok;
    int ns;
    int n;

    #1;
    chk("reset_outputs", {STROBE, READBB, VALID, BUSY, TIMEOUT, RESULT}, 32'd0);
    repeat (3) tick();
    RST_N = 1'b1;
    ce_mode = 0;
    tick();

    // single sample
    data_q = {12'hABC};
    run_seq(0, 0, 200, ok);
    chk("single_done", 32'(ok), 32'd1);
    chk("single_result", 32'(RESULT), 32'h0ABC);
    chk("single_valid_busy", {VALID, BUSY}, 32'b10);
    chk("single_strobe_low_before_valid", 32'(valid_low >= 1), 32'd1);
    chk("single_pulses", pulses, 32'd1);

    // eight full-scale samples
    for (int i = 0; i < 8; i++) data_q.push_back(12'hFFF);
    run_seq(7, 0, 500, ok);
    chk("eight_done", 32'(ok), 32'd1);
    chk("eight_result", 32'(RESULT), 32'h7FF8);
    chk("eight_pulses", pulses, 32'd8);
    chk("eight_gap", 32'(min_low >= GAP + 1), 32'd1);

    // random sample counts and data
    for (int r = 0; r < 4; r++) begin
      ns = int'($urandom_range(0, 7));
      ce_mode = (r == 3) ? 2 : 0;
      run_seq(ns, 0, 3000, ok);
      chk("rand_done", 32'(ok), 32'd1);
      chk("rand_result", 32'(RESULT), 32'(exp_sum));
      chk("rand_pulses", pulses, 32'(ns + 1));
      chk("rand_valid", 32'(VALID), 32'd1);
    end
    ce_mode = 0;
    tick();

    // START while busy is ignored
    run_seq(1, 1, 500, ok);
    chk("busy_done", 32'(ok), 32'd1);
    chk("busy_pulses", pulses, 32'd2);
    chk("busy_result", 32'(RESULT), 32'(exp_sum));
    exp_result = exp_sum;

    // timeout: controller never answers
    c_mode = 1;
    run_seq(0, 0, 200, ok);
    chk("tmo_done", 32'(ok), 32'd1);
    chk("tmo_flags", {TIMEOUT, VALID, STROBE, READBB}, 32'b1000);
    chk("tmo_delay", to_delay, 32'(TMO));
    chk("tmo_result_held", 32'(RESULT), 32'(exp_result));
    repeat (5) tick();
    chk("tmo_sticky", 32'(TIMEOUT), 32'd1);
    c_mode = 0;
    run_seq(0, 0, 200, ok);
    chk("tmo_cleared", {TIMEOUT, VALID}, 32'b01);
    chk("tmo_next_result", 32'(RESULT), 32'(exp_sum));

    // DATAREADY on the timeout cycle: capture wins
    fixed_delay = TMO;
    run_seq(0, 0, 200, ok);
    fixed_delay = 0;
    chk("edge_tmo_flags", {TIMEOUT, VALID}, 32'b01);
    chk("edge_tmo_result", 32'(RESULT), 32'(exp_sum));

    // stale DATAREADY blocks a request
    c_mode = 2;
    DATAREADY = 1'b1;
    NSAMP = 3'd0;
    START = 1'b1;
    repeat (6) tick();
    chk("stale_no_strobe", {STROBE, BUSY}, 32'b00);
    START = 1'b0;
    DATAREADY = 1'b0;
    repeat (3) tick();
    chk("stale_no_late_strobe", 32'(STROBE), 32'd0);
    c_mode = 0;
    run_seq(0, 0, 200, ok);
    chk("stale_then_run", {32'(pulses == 1), VALID}, 32'b11);

    // CE toggling 1-of-3
    ce_mode = 1;
    data_q = {1, 2, 3, 4};
    frz_en = 1;
    frozen_err = 0;
    run_seq(3, 0, 1500, ok);
    frz_en = 0;
    chk("ce_done", 32'(ok), 32'd1);
    chk("ce_result", 32'(RESULT), 32'd10);
    chk("ce_pulses", pulses, 32'd4);
    chk("ce_frozen", frozen_err, 32'd0);
    ce_mode = 0;
    tick();

    // async reset during REQ of the third sample
    seq_init();
    NSAMP = 3'd4;
    START = 1'b1;
    n = 0;
    while (!(pulses == 3 && STROBE) && n < 400) begin
      tick();
      n++;
      if (BUSY) START = 1'b0;
    end
    START = 1'b0;
    chk("rst_reach_req3", 32'(n < 400), 32'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_async_outputs", {STROBE, READBB, VALID, BUSY, TIMEOUT, RESULT}, 32'd0);
    DATAREADY = 1'b0;
    c_cnt = 0;
    strobe_prev = 0;
    valid_prev = 0;
    timeout_prev = 0;
    repeat (2) tick();
    RST_N = 1'b1;
    tick();
    run_seq(2, 0, 300, ok);
    chk("rst_rerun_done", 32'(ok), 32'd1);
    chk("rst_rerun_result", 32'(RESULT), 32'(exp_sum));
    chk("rst_rerun_pulses", pulses, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
